// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_OR, OP_AND} alu_op_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} arb_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Combinational P-bit ALU: ADD/SUB via one adder, plus OR/AND, with NZCV flags.
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int P = 8
) (
  input  logic [P-1:0] a,
  input  logic [P-1:0] b,
  input  alu_op_t      op,
  output logic [P-1:0] result,
  output logic         n,
  output logic         z,
  output logic         c,
  output logic         v
);

  logic         is_sub;
  logic [P-1:0] b_eff;
  logic [P:0]   sum;

  always_comb begin
    is_sub = (op == OP_SUB);
    // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{P{1'b0}}, is_sub};
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum[P-1:0];
        c      = sum[P];
        v      = (a[P-1] == b_eff[P-1]) && (sum[P-1] != a[P-1]);
      end
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
    n = result[P-1];
    z = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one op in flight,
// sequenced IDLE -> EXEC -> RESP, response tagged with the requester id.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int P     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [P-1:0]     req0_a,
  input  logic [P-1:0]     req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [P-1:0]     req1_a,
  input  logic [P-1:0]     req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [P-1:0]     rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  arb_state_t   state, state_nxt;
  logic         last_grant;
  logic         grant0, grant1, accept, win_id;
  logic [P-1:0] a_q, b_q;
  alu_op_t      op_q;
  logic         id_q;

  logic [P-1:0] alu_result;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic [3:0]   alu_flags;

  alu_core #(.P(P)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c),
    .v      (alu_v)
  );

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_n;
    alu_flags[FLAG_Z] = alu_z;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  // Contention goes to whichever requester was not granted last.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == S_IDLE) && grant0;
    req1_ready = (state == S_IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    win_id     = req1_ready;
    state_nxt  = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      ops_done   <= '0;
    end else begin
      if (accept) begin
        a_q        <= win_id ? req1_a : req0_a;
        b_q        <= win_id ? req1_b : req0_b;
        op_q       <= alu_op_t'(win_id ? req1_op : req0_op);
        id_q       <= win_id;
        last_grant <= win_id;
      end
      if (state == S_EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        rsp_id     <= id_q;
        rsp_valid  <= 1'b1;
      end
      if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
